dsc_stream_decoder: RTL and testbench

- Receiving end of the deterministic stochastic-computing datapath: consumes a serial unipolar bitstream (e.g. the output of a DSC multiplier) and converts it to binary.
- Counts the ones over one full frame of 2^(NUM_INPUTS*SNG_WIDTH) valid bits, or fewer if the producer signals early shutoff.
- Presents the result on a valid/ready handshake.
- Sits between the DSC arithmetic core and the binary result consumer.

---
 rtl/dsc_stream_decoder.sv | 109 ++++++++++
 tb/tb_dsc_stream_decoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_stream_decoder.sv
// Serial unipolar bitstream decoder: counts ones over one frame (or until ov_in) and returns it
// on a valid/ready handshake. Optional rounding to SNG_WIDTH bits via DSC_DEC_SCALE_EN.
module dsc_stream_decoder #(
    parameter int unsigned SNG_WIDTH  = 8,
    parameter int unsigned NUM_INPUTS = 2,
    localparam int unsigned OUT_WIDTH = NUM_INPUTS * SNG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sn_in,
    input  logic                 sn_valid,
    input  logic                 ov_in,
    output logic [OUT_WIDTH-1:0] z,
    output logic                 z_valid,
    input  logic                 z_ready,
    output logic                 busy,
    output logic                 early
);

    localparam logic [OUT_WIDTH-1:0] One = OUT_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

    state_e               state_q, state_d;
    logic [OUT_WIDTH-1:0] ones_q, ones_d;
    logic [OUT_WIDTH-1:0] bits_q, bits_d;
    logic [OUT_WIDTH-1:0] z_q, z_d;
    logic                 early_q, early_d;

    logic [OUT_WIDTH-1:0] ones_sat;
    logic [OUT_WIDTH-1:0] result;
    logic                 last_bit;

    // Saturating increment: an all-ones frame must read as all-ones, never wrap to zero.
    assign ones_sat = (sn_valid && sn_in && !(&ones_q)) ? ones_q + One : ones_q;
    assign last_bit = sn_valid && (&bits_q);

`ifdef DSC_DEC_SCALE_EN
    localparam logic [OUT_WIDTH:0] HalfLsb  = (OUT_WIDTH + 1)'(1) << (SNG_WIDTH - 1);
    localparam logic [OUT_WIDTH:0] ScaleMax =
        ((OUT_WIDTH + 1)'(1) << SNG_WIDTH) - (OUT_WIDTH + 1)'(1);

    logic [OUT_WIDTH:0] rounded;

    // Round half-up on the final count; the extra MSB absorbs the carry from 0xFF..F + half.
    assign rounded = ({1'b0, ones_sat} + HalfLsb) >> SNG_WIDTH;
    assign result  = (rounded > ScaleMax) ? ScaleMax[OUT_WIDTH-1:0] : rounded[OUT_WIDTH-1:0];
`else
    assign result = ones_sat;
`endif

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        bits_d  = bits_q;
        z_d     = z_q;
        early_d = early_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ones_d  = '0;
                    bits_d  = '0;
                    state_d = StCount;
                end
            end
            StCount: begin
                ones_d = ones_sat;
                if (sn_valid) begin
                    bits_d = bits_q + One;
                end
                // A full frame wins over a coincident ov_in for the early flag.
                if (last_bit || ov_in) begin
                    state_d = StDone;
                    z_d     = result;
                    early_d = ov_in && !last_bit;
                end
            end
            StDone: begin
                if (z_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ones_q  <= '0;
            bits_q  <= '0;
            z_q     <= '0;
            early_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            bits_q  <= bits_d;
            z_q     <= z_d;
            early_q <= early_d;
        end
    end

    assign z       = z_q;
    assign z_valid = (state_q == StDone);
    assign busy    = (state_q != StIdle);
    assign early   = early_q;

endmodule

// File: tb/tb_dsc_stream_decoder.sv
// Randomised self-checking bench: a default-size decoder and a small (8-bit) one, both compared
// every cycle against a count-based frame model, plus literal pins of key results.
module tb_dsc_stream_decoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic st[2], bi[2], va[2], ov[2], rd[2];
    logic [15:0] z0;
    logic [7:0]  z1;
    logic zv0, zv1, busy0, busy1, early0, early1;

    int errors = 0;
    int checks = 0;

    // Model: phase 0 idle, 1 collecting, 2 result held
    int ph[2], ones[2], bits[2], ez[2];
    bit ee[2];

    dsc_stream_decoder dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .sn_in(bi[0]), .sn_valid(va[0]), .ov_in(ov[0]),
        .z(z0), .z_valid(zv0), .z_ready(rd[0]), .busy(busy0), .early(early0)
    );

    dsc_stream_decoder #(.SNG_WIDTH(4), .NUM_INPUTS(2)) dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .sn_in(bi[1]), .sn_valid(va[1]), .ov_in(ov[1]),
        .z(z1), .z_valid(zv1), .z_ready(rd[1]), .busy(busy1), .early(early1)
    );

    always #5 clk = ~clk;

    function automatic int sw(int s); return (s == 0) ? 8 : 4; endfunction
    function automatic int ow(int s); return 2 * sw(s); endfunction
    function automatic int fr(int s); return 1 << ow(s); endfunction

    function automatic int result(int s, int cnt);
        int c;
        int r;
        c = (cnt > fr(s) - 1) ? fr(s) - 1 : cnt;
`ifdef DSC_DEC_SCALE_EN
        r = (c + (1 << (sw(s) - 1))) >> sw(s);
        if (r > (1 << sw(s)) - 1) r = (1 << sw(s)) - 1;
`else
        r = c;
`endif
        return r;
    endfunction

    function automatic int lit(int raw, int scaled);
`ifdef DSC_DEC_SCALE_EN
        return scaled;
`else
        return raw;
`endif
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int s = 0; s < 2; s++) begin
            ph[s] = 0; ones[s] = 0; bits[s] = 0; ez[s] = 0; ee[s] = 1'b0;
        end
    endtask

    task automatic step(int s);
        bit full;
        full = 1'b0;
        case (ph[s])
            0: if (st[s]) begin ph[s] = 1; ones[s] = 0; bits[s] = 0; end
            1: begin
                if (va[s]) begin
                    bits[s]++;
                    ones[s] += int'(bi[s]);
                    full = (bits[s] == fr(s));
                end
                if (full || ov[s]) begin
                    ph[s] = 2;
                    ez[s] = result(s, ones[s]);
                    ee[s] = ov[s] && !full;
                end
            end
            default: if (rd[s]) ph[s] = 0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) step(s);
    endtask

    function automatic int expv(int s);
        return (int'(ph[s] != 0) << (ow(s) + 2)) | (int'(ph[s] == 2) << (ow(s) + 1)) |
               (int'(ee[s]) << ow(s)) | ez[s];
    endfunction

    always @(negedge clk) begin
        check("cycle_dut0", int'({busy0, zv0, early0, z0}), expv(0));
        check("cycle_dut1", int'({busy1, zv1, early1, z1}), expv(1));
    end

    // gap: 0 none, 1 idle cycle before every bit (with stray start/sn_in), 2 random idles
    task automatic frame(int s, int n, int ones_n, int gap, bit ov_last, bit last_b, bit rnd);
        bit b;
        st[s] = 1'b1;
        tick();
        st[s] = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                va[s] = 1'b0; bi[s] = 1'($urandom); st[s] = 1'b1; ov[s] = 1'b0;
                rd[s] = 1'($urandom);
                tick();
                st[s] = 1'b0;
            end
            b = rnd ? 1'($urandom) : (i < ones_n);
            if (i == n - 1 && ov_last) begin
                b = last_b;
                ov[s] = 1'b1;
            end
            va[s] = 1'b1; bi[s] = b; rd[s] = rnd ? 1'($urandom) : 1'b0;
            tick();
        end
        va[s] = 1'b0; bi[s] = 1'b0; ov[s] = 1'b0; rd[s] = 1'b0;
    endtask

    // Hold off the consumer, poking start/ov_in, then accept and spend one idle cycle.
    task automatic hs(int s, int hold);
        for (int i = 0; i < hold; i++) begin
            rd[s] = 1'b0; st[s] = 1'b1; ov[s] = 1'b1;
            tick();
        end
        st[s] = 1'b0; ov[s] = 1'b0; rd[s] = 1'b1;
        tick();
        rd[s] = 1'b0; ov[s] = 1'b1;
        tick();
        ov[s] = 1'b0;
    endtask

    initial begin
        int n;
        bit ovl;
        for (int s = 0; s < 2; s++) begin
            st[s] = 1'b0; bi[s] = 1'b0; va[s] = 1'b0; ov[s] = 1'b0; rd[s] = 1'b0;
        end
        mreset();
        #1 rst = 1'b1;
        #1;
        check("reset_z", int'(z0), 0);
        check("reset_flags", int'({zv0, busy0, early0}), 0);
        #10 rst = 1'b0;

        frame(1, 256, 64, 0, 1'b0, 1'b0, 1'b0);
        check("normal_z", int'(z1), lit(32'h40, 4));
        check("normal_early", int'(early1), 0);
        hs(1, 0);

        frame(1, 256, 256, 0, 1'b0, 1'b0, 1'b0);
        check("small_all_ones_z", int'(z1), lit(32'hFF, 32'hF));
        hs(1, 1);

        frame(1, 256, 256, 0, 1'b1, 1'b1, 1'b0);
        check("full_and_ov_early", int'(early1), 0);
        check("full_and_ov_z", int'(z1), lit(32'hFF, 32'hF));
        hs(1, 0);

        frame(1, 32'h48, 32'h48, 0, 1'b1, 1'b1, 1'b0);
        check("round_up_z", int'(z1), lit(32'h48, 5));
        hs(1, 0);
        frame(1, 32'h47, 32'h47, 0, 1'b1, 1'b1, 1'b0);
        check("round_down_z", int'(z1), lit(32'h47, 4));
        hs(1, 0);

        frame(1, 256, 0, 1, 1'b0, 1'b0, 1'b1);
        hs(1, 10);
        check("busy_after_accept", int'(busy1), 0);

        frame(0, 300, 100, 0, 1'b1, 1'b1, 1'b0);
        check("early_one_z", int'(z0), lit(101, 0));
        check("early_one_flag", int'(early0), 1);
        hs(0, 2);
        frame(0, 300, 100, 0, 1'b1, 1'b0, 1'b0);
        check("early_zero_z", int'(z0), lit(100, 0));
        hs(0, 0);

        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        for (int i = 0; i < 999; i++) begin
            va[0] = 1'b1; bi[0] = 1'b1;
            tick();
        end
        va[0] = 1'b1; bi[0] = 1'b1;
        #2 rst = 1'b1;
        mreset();
        #1;
        check("midreset_z", int'(z0), 0);
        check("midreset_flags", int'({zv0, busy0, early0}), 0);
        va[0] = 1'b0; bi[0] = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        frame(0, 16, 16, 0, 1'b1, 1'b1, 1'b0);
        check("after_reset_z", int'(z0), lit(16, 0));
        hs(0, 0);

        frame(0, 65536, 65536, 0, 1'b0, 1'b0, 1'b0);
        check("all_ones_z", int'(z0), lit(32'hFFFF, 32'hFF));
        check("all_ones_early", int'(early0), 0);
        hs(0, 0);

        for (int k = 0; k < 12; k++) begin
            n = $urandom_range(1, 256);
            ovl = (n < 256) ? 1'b1 : 1'($urandom);
            frame(1, n, 0, 2, ovl, 1'($urandom), 1'b1);
            hs(1, $urandom_range(0, 5));
        end
        for (int k = 0; k < 4; k++) begin
            frame(0, $urandom_range(1, 500), 0, 2, 1'b1, 1'($urandom), 1'b1);
            hs(0, $urandom_range(0, 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
